// File: rtl/alt_vipcti_common_flow_control_output_buf_if.sv
// Bundle of every non-clock, non-reset signal of the output buffer.
//   master : the surrounding logic (upstream writer, encoder, status block)
//   slave  : the output buffer itself
// Upstream side : write, data_out, end_of_video_out, stall_out
// Control side  : vip_ctrl_valid_out, width_out, height_out, interlaced_out
// Encoder side  : dout_*, encoder_*
// Status        : clear_status, data_overflow, ctrl_overflow, fifo_level
interface alt_vipcti_common_flow_control_output_buf_if #(
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3,
    parameter int unsigned FIFO_DEPTH       = 4
);
    localparam int unsigned DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          write;
    logic [DW-1:0] data_out;
    logic          end_of_video_out;
    logic          stall_out;
    logic          vip_ctrl_valid_out;
    logic [15:0]   width_out;
    logic [15:0]   height_out;
    logic [3:0]    interlaced_out;
    logic          dout_ready;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          encoder_end_of_video;
    logic          encoder_vip_ctrl_send;
    logic          encoder_vip_ctrl_busy;
    logic [15:0]   encoder_width;
    logic [15:0]   encoder_height;
    logic [3:0]    encoder_interlaced;
    logic          clear_status;
    logic          data_overflow;
    logic          ctrl_overflow;
    logic [LW-1:0] fifo_level;

    modport master (
        output write, data_out, end_of_video_out, vip_ctrl_valid_out, width_out, height_out,
               interlaced_out, dout_ready, encoder_vip_ctrl_busy, clear_status,
        input  stall_out, dout_valid, dout_data, encoder_end_of_video, encoder_vip_ctrl_send,
               encoder_width, encoder_height, encoder_interlaced, data_overflow,
               ctrl_overflow, fifo_level
    );

    modport slave (
        input  write, data_out, end_of_video_out, vip_ctrl_valid_out, width_out, height_out,
               interlaced_out, dout_ready, encoder_vip_ctrl_busy, clear_status,
        output stall_out, dout_valid, dout_data, encoder_end_of_video, encoder_vip_ctrl_send,
               encoder_width, encoder_height, encoder_interlaced, data_overflow,
               ctrl_overflow, fifo_level
    );
endinterface

// File: rtl/alt_vipcti_common_flow_control_output_buf.sv
// Output buffer between a video pipeline and a stream encoder.
// Data path   : first-word-fall-through FIFO of {end_of_video, beat}, registered stall with one
//               beat of skid, sticky data_overflow when a beat is dropped on a full FIFO.
// Control path: small queue of {width, height, interlaced} control packets drained by a
//               three-state sender (idle, send, guard) that pulses encoder_vip_ctrl_send for
//               one cycle; a push into a full queue replaces the newest entry.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of the buffer interface (see the interface file)
module alt_vipcti_common_flow_control_output_buf #(
    parameter int unsigned BITS_PER_SYMBOL    = 8,
    parameter int unsigned SYMBOLS_PER_BEAT   = 3,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter int unsigned CTRL_QUEUE_DEPTH   = 2,
    parameter logic [15:0] WIDTH_DEFAULT      = 16'd640,
    parameter logic [15:0] HEIGHT_DEFAULT     = 16'd480,
    parameter logic [3:0]  INTERLACED_DEFAULT = 4'd0
) (
    input logic clk,
    input logic rst_n,
    alt_vipcti_common_flow_control_output_buf_if.slave bus
);
    localparam int unsigned DW  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned CAW = $clog2(CTRL_QUEUE_DEPTH);
    localparam int unsigned CCW = CAW + 1;
    localparam int unsigned CW  = 36;

    // ------------------------------------------------------------------
    // Data FIFO
    // ------------------------------------------------------------------
    logic [DW:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic          stall_q;
    logic          data_ovf_q;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_drop;
    logic [DW:0]   fifo_head;

    assign fifo_full = (level == LW'(FIFO_DEPTH));
    assign fifo_pop  = (level != '0) && bus.dout_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign fifo_push = bus.write && (!fifo_full || fifo_pop);
    assign fifo_drop = bus.write && fifo_full && !fifo_pop;
    assign fifo_head = fifo_mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (fifo_push && !fifo_pop) begin
            level_next = level + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= {bus.end_of_video_out, bus.data_out};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            stall_q    <= 1'b0;
            data_ovf_q <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            // Raised one entry early so a beat already in flight still has a slot.
            stall_q <= (level_next >= LW'(FIFO_DEPTH - 1));
            if (fifo_drop) begin
                data_ovf_q <= 1'b1;
            end else if (bus.clear_status) begin
                data_ovf_q <= 1'b0;
            end
        end
    end

    assign bus.dout_valid           = (level != '0);
    assign bus.dout_data            = fifo_head[DW-1:0];
    assign bus.encoder_end_of_video = fifo_head[DW];
    assign bus.fifo_level           = level;
    assign bus.stall_out            = stall_q;
    assign bus.data_overflow        = data_ovf_q;

    // ------------------------------------------------------------------
    // Control-packet queue
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StSend, StGuard} ctrl_state_e;

    ctrl_state_e    state;
    logic [CW-1:0]  cq_mem [CTRL_QUEUE_DEPTH];
    logic [CAW-1:0] cq_wr;
    logic [CAW-1:0] cq_rd;
    logic [CAW-1:0] cq_tail;
    logic [CCW-1:0] cq_count;
    logic           cq_full;
    logic           cq_pop;
    logic           cq_push;
    logic           cq_overwrite;
    logic [CW-1:0]  cq_in;
    logic [CW-1:0]  cq_head;
    logic [CW-1:0]  sent_q;
    logic           send_q;
    logic           ctrl_ovf_q;

    assign cq_in        = {bus.width_out, bus.height_out, bus.interlaced_out};
    assign cq_head      = cq_mem[cq_rd];
    assign cq_tail      = cq_wr - 1'b1;
    assign cq_full      = (cq_count == CCW'(CTRL_QUEUE_DEPTH));
    assign cq_pop       = (state == StSend);
    // A send frees the head slot, so a push on a full queue is then an ordinary push.
    assign cq_push      = bus.vip_ctrl_valid_out && (!cq_full || cq_pop);
    assign cq_overwrite = bus.vip_ctrl_valid_out && cq_full && !cq_pop;

    always_ff @(posedge clk) begin
        if (cq_push) begin
            cq_mem[cq_wr] <= cq_in;
        end else if (cq_overwrite) begin
            cq_mem[cq_tail] <= cq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cq_wr      <= '0;
            cq_rd      <= '0;
            cq_count   <= '0;
            ctrl_ovf_q <= 1'b0;
        end else begin
            if (cq_push) begin
                cq_wr <= cq_wr + 1'b1;
            end
            if (cq_pop) begin
                cq_rd <= cq_rd + 1'b1;
            end
            if (cq_push && !cq_pop) begin
                cq_count <= cq_count + 1'b1;
            end else if (!cq_push && cq_pop) begin
                cq_count <= cq_count - 1'b1;
            end
            if (cq_overwrite) begin
                ctrl_ovf_q <= 1'b1;
            end else if (bus.clear_status) begin
                ctrl_ovf_q <= 1'b0;
            end
        end
    end

    // Sender: the guard state enforces at least three cycles between send pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= StIdle;
            send_q <= 1'b0;
            sent_q <= {WIDTH_DEFAULT, HEIGHT_DEFAULT, INTERLACED_DEFAULT};
        end else begin
            send_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if ((cq_count != '0) && !bus.encoder_vip_ctrl_busy) begin
                        state  <= StSend;
                        send_q <= 1'b1;
                    end
                end
                StSend: begin
                    state  <= StGuard;
                    sent_q <= cq_head;
                end
                StGuard: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.encoder_vip_ctrl_send = send_q;
    // During the send cycle the encoder sees the packet it is being told to send.
    assign bus.encoder_width      = send_q ? cq_head[35:20] : sent_q[35:20];
    assign bus.encoder_height     = send_q ? cq_head[19:4]  : sent_q[19:4];
    assign bus.encoder_interlaced = send_q ? cq_head[3:0]   : sent_q[3:0];
    assign bus.ctrl_overflow      = ctrl_ovf_q;

endmodule

// File: tb/tb_alt_vipcti_common_flow_control_output_buf.sv
module tb_alt_vipcti_common_flow_control_output_buf;
    localparam int D  = 4;
    localparam int CD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alt_vipcti_common_flow_control_output_buf_if #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .FIFO_DEPTH(D)
    ) bus ();

    alt_vipcti_common_flow_control_output_buf #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .FIFO_DEPTH(D), .CTRL_QUEUE_DEPTH(CD),
        .WIDTH_DEFAULT(16'd640), .HEIGHT_DEFAULT(16'd480), .INTERLACED_DEFAULT(4'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues plus a "cycles since last send" counter.
    logic [24:0] dq[$];
    logic [35:0] cq[$];
    logic [35:0] reg_m;
    bit          stall_m, dovf_m, covf_m, send_m;
    int          age;

    task automatic model_edge();
        bit pop, push, full, sending, elig;
        logic [35:0] pkt;
        if (!rst_n) begin
            dq.delete();
            cq.delete();
            reg_m  = {16'd640, 16'd480, 4'd0};
            stall_m = 0; dovf_m = 0; covf_m = 0; send_m = 0;
            age = 2;
        end else begin
            full = (dq.size() == D);
            pop  = (dq.size() != 0) && bus.dout_ready;
            push = bus.write && (!full || pop);
            if (pop) void'(dq.pop_front());
            if (push) dq.push_back({bus.end_of_video_out, bus.data_out});
            if (bus.write && full && !pop) dovf_m = 1;
            else if (bus.clear_status) dovf_m = 0;
            stall_m = (dq.size() >= D - 1);

            sending = send_m;
            elig = !sending && (age >= 2) && (cq.size() != 0) && !bus.encoder_vip_ctrl_busy;
            full = (cq.size() == CD);
            pkt  = {bus.width_out, bus.height_out, bus.interlaced_out};
            if (sending) reg_m = cq.pop_front();
            if (bus.vip_ctrl_valid_out) begin
                if (full && !sending) begin
                    cq[cq.size() - 1] = pkt;
                    covf_m = 1;
                end else begin
                    cq.push_back(pkt);
                end
            end
            if (!(bus.vip_ctrl_valid_out && full && !sending) && bus.clear_status) covf_m = 0;
            send_m = elig;
            age = elig ? 0 : ((age >= 2) ? 2 : age + 1);
        end
    endtask

    function automatic logic [35:0] exp_ctrl();
        return send_m ? cq[0] : reg_m;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.write = 0; bus.data_out = '0; bus.end_of_video_out = 0;
        bus.vip_ctrl_valid_out = 0; bus.width_out = '0; bus.height_out = '0;
        bus.interlaced_out = '0; bus.dout_ready = 0; bus.encoder_vip_ctrl_busy = 0;
        bus.clear_status = 0;
    endtask

    task automatic push_ctrl(input logic [15:0] w, input logic [15:0] h);
        bus.vip_ctrl_valid_out = 1; bus.width_out = w; bus.height_out = h;
        bus.interlaced_out = 4'd0;
        tick();
        bus.vip_ctrl_valid_out = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.dout_valid); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall_out); end
        checks++; if ({bus.data_overflow, bus.ctrl_overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b want 00", bus.data_overflow, bus.ctrl_overflow); end
        checks++; if ({bus.encoder_width, bus.encoder_height, bus.encoder_interlaced} !== {16'd640, 16'd480, 4'd0}) begin errors++; $display("FAIL reset_ctrl got %0d/%0d/%0d want 640/480/0", bus.encoder_width, bus.encoder_height, bus.encoder_interlaced); end
        rst_n = 1;
        tick();
        checks++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin errors++; $display("FAIL reset_send got %b want 0", bus.encoder_vip_ctrl_send); end
    endtask

    task automatic test_fill_overflow();
        logic [24:0] exp;
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            bus.write = 1; bus.data_out = 24'(i); bus.end_of_video_out = (i == 3);
            tick();
            checks++; if (bus.fifo_level !== 3'(i)) begin errors++; $display("FAIL fill_level beat %0d got %0d want %0d", i, bus.fifo_level, i); end
            checks++; if (bus.stall_out !== (i >= 3)) begin errors++; $display("FAIL fill_stall beat %0d got %b want %b", i, bus.stall_out, (i >= 3)); end
        end
        checks++; if ({bus.dout_valid, bus.dout_data} !== {1'b1, 24'h01}) begin errors++; $display("FAIL fill_head got %b/%h want 1/000001", bus.dout_valid, bus.dout_data); end
        bus.data_out = 24'h05; bus.end_of_video_out = 0;
        tick();
        bus.write = 0;
        checks++; if (bus.data_overflow !== 1'b1) begin errors++; $display("FAIL drop_flag got %b want 1", bus.data_overflow); end
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL drop_level got %0d want 4", bus.fifo_level); end
        bus.dout_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            exp = {1'(i == 3), 24'(i)};
            checks++; if ({bus.encoder_end_of_video, bus.dout_data} !== exp) begin errors++; $display("FAIL drain_beat %0d got %h want %h", i, {bus.encoder_end_of_video, bus.dout_data}, exp); end
            tick();
        end
        checks++; if ({bus.dout_valid, bus.fifo_level, bus.stall_out} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("FAIL drain_empty got %b/%0d/%b want 0/0/0", bus.dout_valid, bus.fifo_level, bus.stall_out); end
        bus.clear_status = 1;
        tick();
        bus.clear_status = 0;
        checks++; if (bus.data_overflow !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", bus.data_overflow); end
    endtask

    task automatic test_ctrl_send();
        int pulses = 0; int k0 = -1; int k1 = -1;
        logic [15:0] w0 = '0, h0 = '0, w1 = '0, h1 = '0;
        idle_inputs();
        push_ctrl(16'd1920, 16'd1080);
        push_ctrl(16'd1280, 16'd720);
        for (int k = 0; k < 8; k++) begin
            if (bus.encoder_vip_ctrl_send) begin
                if (pulses == 0) begin k0 = k; w0 = bus.encoder_width; h0 = bus.encoder_height; end
                else if (pulses == 1) begin k1 = k; w1 = bus.encoder_width; h1 = bus.encoder_height; end
                pulses++;
            end
            tick();
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL send_count got %0d want 2", pulses); end
        checks++; if (k0 !== 0) begin errors++; $display("FAIL send_first_cycle got %0d want 0", k0); end
        checks++; if (k1 - k0 !== 3) begin errors++; $display("FAIL send_spacing got %0d want 3", k1 - k0); end
        checks++; if ({w0, h0} !== {16'd1920, 16'd1080}) begin errors++; $display("FAIL send_first got %0dx%0d want 1920x1080", w0, h0); end
        checks++; if ({w1, h1} !== {16'd1280, 16'd720}) begin errors++; $display("FAIL send_second got %0dx%0d want 1280x720", w1, h1); end
        checks++; if ({bus.encoder_width, bus.encoder_height} !== {16'd1280, 16'd720}) begin errors++; $display("FAIL send_hold got %0dx%0d want 1280x720", bus.encoder_width, bus.encoder_height); end
    endtask

    task automatic test_ctrl_overflow();
        int pulses = 0;
        logic [15:0] w0 = '0, w1 = '0;
        idle_inputs();
        bus.encoder_vip_ctrl_busy = 1;
        push_ctrl(16'd100, 16'd10);
        push_ctrl(16'd200, 16'd20);
        push_ctrl(16'd300, 16'd30);
        tick();
        checks++; if (bus.ctrl_overflow !== 1'b1) begin errors++; $display("FAIL cq_ovf got %b want 1", bus.ctrl_overflow); end
        checks++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin errors++; $display("FAIL cq_busy_send got %b want 0", bus.encoder_vip_ctrl_send); end
        bus.encoder_vip_ctrl_busy = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.encoder_vip_ctrl_send) begin
                if (pulses == 0) w0 = bus.encoder_width; else if (pulses == 1) w1 = bus.encoder_width;
                pulses++;
            end
            tick();
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL cq_send_count got %0d want 2", pulses); end
        checks++; if ({w0, w1} !== {16'd100, 16'd300}) begin errors++; $display("FAIL cq_order got %0d,%0d want 100,300", w0, w1); end
        bus.clear_status = 1;
        tick();
        bus.clear_status = 0;
        checks++; if (bus.ctrl_overflow !== 1'b0) begin errors++; $display("FAIL cq_clear got %b want 0", bus.ctrl_overflow); end
    endtask

    task automatic test_clear_status();
        idle_inputs();
        bus.encoder_vip_ctrl_busy = 1;
        for (int i = 0; i < 4; i++) begin
            bus.write = 1; bus.data_out = 24'($urandom);
            bus.vip_ctrl_valid_out = (i < 2); bus.width_out = 16'(i + 1);
            tick();
        end
        bus.vip_ctrl_valid_out = 1; bus.clear_status = 1;
        tick();
        checks++; if ({bus.data_overflow, bus.ctrl_overflow} !== 2'b11) begin errors++; $display("FAIL set_wins got %b%b want 11", bus.data_overflow, bus.ctrl_overflow); end
        bus.write = 0; bus.vip_ctrl_valid_out = 0;
        tick();
        checks++; if ({bus.data_overflow, bus.ctrl_overflow} !== 2'b00) begin errors++; $display("FAIL clear_both got %b%b want 00", bus.data_overflow, bus.ctrl_overflow); end
        bus.clear_status = 0; bus.dout_ready = 1; bus.encoder_vip_ctrl_busy = 0;
        for (int k = 0; k < 12; k++) tick();
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL clear_drain got %0d want 0", bus.fifo_level); end
    endtask

    task automatic test_reset_mid_send();
        bit found = 0;
        idle_inputs();
        bus.write = 1; bus.data_out = 24'hAA;
        tick();
        bus.data_out = 24'hBB;
        push_ctrl(16'd1920, 16'd1080);
        bus.write = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            if (bus.encoder_vip_ctrl_send) found = 1; else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_send_seen got 0 want 1"); end
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++; if ({bus.dout_valid, bus.fifo_level, bus.stall_out} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("FAIL rst_data got %b/%0d/%b want 0/0/0", bus.dout_valid, bus.fifo_level, bus.stall_out); end
        checks++; if ({bus.encoder_width, bus.encoder_height, bus.encoder_interlaced} !== {16'd640, 16'd480, 4'd0}) begin errors++; $display("FAIL rst_ctrl got %0d/%0d/%0d want 640/480/0", bus.encoder_width, bus.encoder_height, bus.encoder_interlaced); end
        checks++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin errors++; $display("FAIL rst_send got %b want 0", bus.encoder_vip_ctrl_send); end
        tick();
        checks++; if ({bus.encoder_vip_ctrl_send, bus.encoder_width} !== {1'b0, 16'd640}) begin errors++; $display("FAIL rst_after got %b/%0d want 0/640", bus.encoder_vip_ctrl_send, bus.encoder_width); end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 500; n++) begin
            bus.write = ($urandom_range(0, 99) < 60) && (!bus.stall_out || $urandom_range(0, 4) == 0);
            bus.data_out = 24'($urandom);
            bus.end_of_video_out = ($urandom_range(0, 9) == 0);
            bus.dout_ready = ($urandom_range(0, 1) == 1);
            bus.vip_ctrl_valid_out = ($urandom_range(0, 99) < 20);
            bus.width_out = 16'($urandom); bus.height_out = 16'($urandom);
            bus.interlaced_out = 4'($urandom);
            bus.encoder_vip_ctrl_busy = ($urandom_range(0, 99) < 30);
            bus.clear_status = ($urandom_range(0, 19) == 0);
            tick();
            checks++; if (bus.dout_valid !== (dq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, bus.dout_valid, (dq.size() != 0)); end
            checks++; if (bus.fifo_level !== 3'(dq.size())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", n, bus.fifo_level, dq.size()); end
            if (dq.size() != 0) begin
                checks++; if ({bus.encoder_end_of_video, bus.dout_data} !== dq[0]) begin errors++; $display("FAIL rnd_head cyc %0d got %h want %h", n, {bus.encoder_end_of_video, bus.dout_data}, dq[0]); end
            end
            checks++; if (bus.stall_out !== stall_m) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", n, bus.stall_out, stall_m); end
            checks++; if ({bus.data_overflow, bus.ctrl_overflow} !== {dovf_m, covf_m}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b%b want %b%b", n, bus.data_overflow, bus.ctrl_overflow, dovf_m, covf_m); end
            checks++; if (bus.encoder_vip_ctrl_send !== send_m) begin errors++; $display("FAIL rnd_send cyc %0d got %b want %b", n, bus.encoder_vip_ctrl_send, send_m); end
            checks++; if ({bus.encoder_width, bus.encoder_height, bus.encoder_interlaced} !== exp_ctrl()) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %h want %h", n, {bus.encoder_width, bus.encoder_height, bus.encoder_interlaced}, exp_ctrl()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_ctrl_send();
        test_ctrl_overflow();
        test_clear_status();
        test_reset_mid_send();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
